// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and default widths for the skid-buffered pipeline boundary register.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W_DEF = 2;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bus between an upstream producer, the stage, and a downstream consumer.
// A transfer happens on a rising edge where valid and ready are both 1; valid and its
// payload are held stable by the sender until that edge, and ready never waits on valid.
interface pipe_stage_skid_if #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One payload register with synchronous clear (dominant) and load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a 2-entry skid, global stall, flush and squash counter.
// in_ready and out_valid are flops, so no combinational path crosses the stage.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    pipe_stage_skid_if.slave  bus,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  squash_cnt
);
    localparam int PW = DATA_W + CTRL_W;

    occ_t             occ_q, occ_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic [CNT_W:0]   squash_sum;

    logic [PW-1:0]    main_q, main_d, skid_q, in_word;
    logic             main_load, skid_load;
    logic             accept, issue;

    assign in_word = {bus.in_data, bus.in_ctrl};
    assign accept  = bus.in_valid  & in_ready_q  & en & ~flush;
    assign issue   = out_valid_q   & bus.out_ready & en & ~flush;

    always_comb begin
        occ_d     = occ_q;
        main_d    = in_word;
        main_load = 1'b0;
        skid_load = 1'b0;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    occ_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && issue) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    occ_d     = OCC_TWO;
                end else if (issue) begin
                    // Payload is kept for inspection; only the strobes are dropped.
                    main_d    = {main_q[PW-1:CTRL_W], {CTRL_W{1'b0}}};
                    main_load = 1'b1;
                    occ_d     = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (issue) begin
                    main_d    = skid_q;
                    main_load = 1'b1;
                    occ_d     = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            occ_d     = OCC_EMPTY;
        end
    end

    always_comb begin
        squash_sum = {1'b0, squash_q} + (CNT_W + 1)'(occ_q);
        squash_d   = squash_q;
        if (flush) begin
            squash_d = squash_sum[CNT_W] ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q       <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            squash_q    <= '0;
        end else begin
            occ_q       <= occ_d;
            in_ready_q  <= (occ_d != OCC_TWO);
            out_valid_q <= (occ_d != OCC_EMPTY);
            squash_q    <= squash_d;
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (main_load),
        .clear_i (flush),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (skid_load),
        .clear_i (flush),
        .d_i     (in_word),
        .q_o     (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q[PW-1:CTRL_W];
    assign bus.out_ctrl  = main_q[CTRL_W-1:0] & {CTRL_W{out_valid_q}};
    assign occupancy     = occ_q;
    assign squash_cnt    = squash_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, stall, flush,
// counter saturation (2-bit instance) and asynchronous reset.
module tb_pipe_stage_skid;
  logic clk;
  logic reset;
  logic en, flush;
  logic s_en, s_flush;
  logic [1:0] occupancy, s_occupancy;
  logic [7:0] squash_cnt;
  logic [1:0] s_squash_cnt;

  int checks;
  int errors;

  pipe_stage_skid_if #(.DATA_W(16), .CTRL_W(2)) bus ();
  pipe_stage_skid_if #(.DATA_W(16), .CTRL_W(2)) sbus ();

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .flush      (flush),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .squash_cnt (squash_cnt)
  );

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(2), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .en         (s_en),
    .flush      (s_flush),
    .bus        (sbus.slave),
    .occupancy  (s_occupancy),
    .squash_cnt (s_squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    en = 1'b1; flush = 1'b0;
    s_en = 1'b1; s_flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_ctrl = '0; sbus.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_squash", 32'(squash_cnt), 32'd0);
    chk("rst_out_ctrl", 32'(bus.out_ctrl), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Streaming with out_ready held high: one word per cycle, 1-cycle latency.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = 16'(i);
      tick();
      chk("stream_data", 32'(bus.out_data), 32'(i));
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_ctrl", 32'(bus.out_ctrl), 32'd1);
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_ctrl", 32'(bus.out_ctrl), 32'd0);
    chk("drain_data_kept", 32'(bus.out_data), 32'h5);

    // Backpressure fills the skid; the third word waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 2'b10;
    bus.in_data   = 16'hAAAA;
    tick();
    chk("bp_first_occ", 32'(occupancy), 32'd1);
    chk("bp_first_data", 32'(bus.out_data), 32'hAAAA);
    bus.in_data = 16'hBBBB;
    tick();
    chk("bp_full_occ", 32'(occupancy), 32'd2);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 16'hCCCC;
    tick();
    chk("bp_hold_occ", 32'(occupancy), 32'd2);
    chk("bp_hold_data", 32'(bus.out_data), 32'hAAAA);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_data_b", 32'(bus.out_data), 32'hBBBB);
    chk("bp_rel_occ", 32'(occupancy), 32'd1);
    chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_rel_data_c", 32'(bus.out_data), 32'hCCCC);
    chk("bp_rel_occ_c", 32'(occupancy), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drain_occ", 32'(occupancy), 32'd0);

    // Stall with one entry held.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 2'b01;
    bus.in_data   = 16'h5555;
    tick();
    chk("stall_pre_occ", 32'(occupancy), 32'd1);
    en = 1'b0;
    bus.in_data   = 16'h6666;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_occ", 32'(occupancy), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'h5555);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd1);
    end
    en = 1'b1;
    tick();
    chk("stall_resume_data", 32'(bus.out_data), 32'h6666);
    chk("stall_resume_occ", 32'(occupancy), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("stall_drain_occ", 32'(occupancy), 32'd0);

    // Flush with two entries held and a simultaneous input.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 2'b11;
    bus.in_data   = 16'h0A0A;
    tick();
    bus.in_data = 16'h0B0B;
    tick();
    chk("flush_pre_occ", 32'(occupancy), 32'd2);
    flush = 1'b1;
    bus.in_data = 16'h1234;
    tick();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ctrl", 32'(bus.out_ctrl), 32'd0);
    chk("flush_squash", 32'(squash_cnt), 32'd2);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("flush_no_deliver", 32'(bus.out_valid), 32'd0);
    chk("flush_data_cleared", 32'(bus.out_data), 32'h0);

    // Flush while stalled still squashes the single held entry.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h7777;
    tick();
    bus.in_valid = 1'b0;
    en    = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_stalled_occ", 32'(occupancy), 32'd0);
    chk("flush_stalled_squash", 32'(squash_cnt), 32'd3);
    en    = 1'b1;
    flush = 1'b0;

    // Saturation on the 2-bit counter instance.
    for (int r = 0; r < 3; r++) begin
      sbus.out_ready = 1'b0;
      sbus.in_valid  = 1'b1;
      sbus.in_data   = 16'(16'h100 + r);
      tick();
      tick();
      chk("sat_fill_occ", 32'(s_occupancy), 32'd2);
      sbus.in_valid = 1'b0;
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      chk("sat_squash", 32'(s_squash_cnt), (r == 0) ? 32'd2 : 32'd3);
      chk("sat_occ", 32'(s_occupancy), 32'd0);
    end

    // Asynchronous reset with two entries held.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 2'b01;
    bus.in_data   = 16'hDEAD;
    tick();
    bus.in_data = 16'hBEEF;
    tick();
    chk("arst_pre_occ", 32'(occupancy), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_data", 32'(bus.out_data), 32'h0);
    chk("arst_squash", 32'(squash_cnt), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_squash", 32'(squash_cnt), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-boundary register, the successor to the fixed per-signal MEM/WB flop bank.
- Carries one data payload and one control bundle between core stages under a valid/ready handshake.
- Provides global stall (en), synchronous flush with bubble insertion, and a 2-entry skid so in_ready never depends combinationally on out_ready.
- Maintains a saturating count of squashed (flushed) valid entries for debug.

Parameters:
- DATA_W, 16: payload width (ALU result, read data, extended immediate, flags, concatenated by the instantiator).
- CTRL_W, 2: control-bit width (regwrite-type strobes); forced to 0 whenever no valid entry is presented.
- CNT_W, 8: squash counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  stage enable; 0 = stall (no transfers, state held)
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, equals "skid slot empty"
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  main slot holds a valid entry
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main slot payload
- out_ctrl  out  CTRL_W  main slot control, gated by out_valid
- occupancy  out  2  held entries, 0..2
- squash_cnt  out  CNT_W  saturating count of entries discarded by flush

Behaviour:
- Reset (reset=0, asynchronous): both slots cleared (data and ctrl = 0); occupancy = 0; out_valid = 0; in_ready = 1; squash_cnt = 0.
- Definitions: accept = in_valid & in_ready & en & ~flush; issue = out_valid & out_ready & en & ~flush.
- State is occupancy: EMPTY(0), ONE(1) (main valid), TWO(2) (main and skid valid).
- EMPTY: accept -> main <= in, go to ONE. issue is impossible in EMPTY.
- ONE, accept & issue: main <= in, stay in ONE.
- ONE, accept & ~issue: skid <= in, go to TWO.
- ONE, ~accept & issue: go to EMPTY; main data retained, main ctrl cleared.
- TWO: in_ready = 0. issue -> main <= skid, go to ONE. Otherwise hold.
- Latency: 1 cycle from accept to out_valid when the stage was empty. Throughput: 1 entry per cycle when out_ready is held at 1.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- en = 0: no transfer, all registers hold; in_ready and out_valid still reflect state.
- flush = 1 (acts regardless of en; priority over all transfers):
  - both slots cleared; occupancy <= 0; the input in the same cycle is not accepted;
  - squash_cnt += occupancy before the flush, saturating at 2^CNT_W-1.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}, so a bubble can never assert a write strobe.
- No combinational path from out_ready to in_ready. in_valid/in_data to outputs is registered only.
- Reset asserted mid-transfer discards everything immediately; squash_cnt is not incremented by reset.

Decomposition:
- pipe_pkg holds:
  - typedef enum logic [1:0] occ_t {OCC_EMPTY, OCC_ONE, OCC_TWO};
  - default width constants DATA_W_DEF = 16, CTRL_W_DEF = 2.
- Sub-module pipe_slot (parametrised W): one payload register with load, clear, and async active-low reset. Instantiated twice, for main and skid.

Test Plan:
- Reset then stream: in_data 0x0001..0x0005, in_ctrl = 2'b01, out_ready = 1 continuously -> out_data 0x0001..0x0005 on consecutive cycles, 1-cycle latency, occupancy never exceeds 1, in_ready stays 1.
- Backpressure: out_ready = 0 while sending 0xAAAA, 0xBBBB -> occupancy 2 and in_ready = 0 on the cycle after the second accept; third word 0xCCCC is held off. Release out_ready -> 0xAAAA, 0xBBBB, 0xCCCC delivered in order.
- Stall: with occupancy 1, en = 0 for 3 cycles while in_valid = 1 and out_ready = 1 -> no state change, out_data constant. Normal flow resumes on the cycle en returns to 1.
- Flush with 2 held entries plus simultaneous in_valid (0x1234) -> next cycle occupancy 0, out_valid 0, out_ctrl 0, squash_cnt +2, 0x1234 not delivered.
- Saturation: CNT_W = 2, three flushes each with occupancy 2 -> squash_cnt reads 2, then 3, then 3.
- Async reset asserted mid-stream with occupancy 2 -> outputs cleared without a clock edge. After deassert: in_ready = 1, squash_cnt = 0.
